// File: rtl/router_pkt_ctrl_if.sv
// Packet router control bus: upstream byte handshake plus the downstream
// FIFO write port and status flags. The router drives the "slave" side;
// the packet source and output FIFOs sit on the "master" side.
interface router_pkt_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic       busy;
  logic [2:0] wr_en;
  logic [7:0] data_out;
  logic       pkt_done;
  logic       err;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    output busy, wr_en, data_out, pkt_done, err
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    input  busy, wr_en, data_out, pkt_done, err
  );
endinterface

// File: rtl/router_pkt_ctrl.sv
// Packet router controller. Accepts a header byte (dest in [1:0], len in
// [7:2]), len payload bytes and one parity byte, steering header and payload
// to one of three output FIFOs. dest==3 packets are consumed and dropped.
// Optional feature: define ROUTER_PARITY_CHK_EN to keep a running XOR of the
// header and payload and flag a mismatching parity byte on err. Without it
// the parity byte is only consumed and err reports dropped packets alone.
module router_pkt_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  router_pkt_ctrl_if.slave  io_pkt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_PARITY  = 3'd2,
    S_DROP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_dest;
  logic [5:0] r_count;
  logic       r_pkt_done;
  logic       r_err;
`ifdef ROUTER_PARITY_CHK_EN
  logic [7:0] r_parity;
`endif

  logic [1:0] w_hdr_dest;
  logic [3:0] w_full4;
  logic       w_busy;
  logic       w_accept;
  logic [2:0] w_wr_en;

  // Backpressure, acceptance and zero-latency FIFO write steering.
  // NOTE: every signal gets a default at the top of an always_comb so that
  // no path through the case statement can leave it unassigned (no latches).
  always_comb begin
    w_hdr_dest = io_pkt.data_in[1:0];
    // Padded with a constant 0 so dest==3 indexes a real bit and never stalls.
    w_full4    = {1'b0, io_pkt.fifo_full};
    w_busy     = 1'b0;
    w_wr_en    = 3'b000;
    case (r_state)
      S_IDLE:    w_busy = io_pkt.pkt_valid && (w_hdr_dest != 2'd3) && w_full4[w_hdr_dest];
      S_PAYLOAD: w_busy = w_full4[r_dest];
      S_DONE:    w_busy = 1'b1;
      default:   w_busy = 1'b0;
    endcase
    // Outputs stay quiet while reset is held, whatever upstream is driving.
    if (!rst_n) w_busy = 1'b0;
    w_accept = io_pkt.pkt_valid && !w_busy && rst_n;
    if (w_accept) begin
      case (r_state)
        S_IDLE:    if (w_hdr_dest != 2'd3) w_wr_en = 3'b001 << w_hdr_dest;
        S_PAYLOAD: w_wr_en = 3'b001 << r_dest;
        default:   w_wr_en = 3'b000;
      endcase
    end
  end

  assign io_pkt.busy     = w_busy;
  assign io_pkt.wr_en    = w_wr_en;
  assign io_pkt.data_out = io_pkt.data_in;
  assign io_pkt.pkt_done = r_pkt_done;
  assign io_pkt.err      = r_err;

  // Packet-sequencing FSM with registered pkt_done/err.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order. The reset
  // branch is asynchronous so a mid-packet reset aborts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dest     <= 2'd0;
      r_count    <= 6'd0;
      r_pkt_done <= 1'b0;
      r_err      <= 1'b0;
`ifdef ROUTER_PARITY_CHK_EN
      r_parity   <= 8'h00;
`endif
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_err   <= 1'b0;
            r_count <= io_pkt.data_in[7:2];
            if (w_hdr_dest != 2'd3) begin
              r_dest  <= w_hdr_dest;
`ifdef ROUTER_PARITY_CHK_EN
              r_parity <= io_pkt.data_in;
`endif
              r_state <= (io_pkt.data_in[7:2] != 6'd0) ? S_PAYLOAD : S_PARITY;
            end else begin
              r_state <= S_DROP;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
`ifdef ROUTER_PARITY_CHK_EN
            r_parity <= r_parity ^ io_pkt.data_in;
`endif
            // Saturating decrement: the count never wraps below zero.
            if (r_count > 6'd1) begin
              r_count <= r_count - 6'd1;
            end else begin
              r_count <= 6'd0;
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_accept) begin
`ifdef ROUTER_PARITY_CHK_EN
            r_err <= (io_pkt.data_in != r_parity);
`else
            r_err <= 1'b0;
`endif
            r_pkt_done <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DROP: begin
          // len payload bytes plus the parity byte are swallowed.
          if (w_accept) begin
            if (r_count == 6'd0) begin
              r_err      <= 1'b1;
              r_pkt_done <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_count <= r_count - 6'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
